dfi_latency_ctrl: RTL and testbench
===================================

DFI_LATENCY_CTRL -- requirements
Module: dfi_latency_ctrl

Interface
REQ-001 SHALL have parameter NPHASES, default 2: DFI phases per sys_clk cycle; legal range 1..4.
REQ-002 SHALL have parameter WRLAT, default 2: sys_clk cycles from write enable to first drive cycle; legal range 2..8.
REQ-003 SHALL have parameter RDLAT, default 5: sys_clk cycles from read enable to first valid cycle; legal range 1..16.
REQ-004 SHALL have parameter BURST, default 1: sys_clk cycles of data per command; legal range 1..4.
REQ-005 SHALL have parameter WRPHASE, default 1: the only phase index accepted for writes.
REQ-006 SHALL have parameter RDPHASE, default 0: the only phase index accepted for reads.
REQ-007 SHALL have port sys_clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-008 SHALL have port sys_rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-009 SHALL have port dfi_wrdata_en, input, NPHASES bits: per-phase write enable (bit p = phase p).
REQ-010 SHALL have port dfi_rddata_en, input, NPHASES bits: per-phase read enable.
REQ-011 SHALL have port drive_dq, output, NPHASES bits: DQ/DM output enable per phase slot.
REQ-012 SHALL have port drive_dqs, output, NPHASES bits: DQS output enable per phase slot.
REQ-013 SHALL have port dqs_preamble, output, 1 bit: DQS preamble cycle.
REQ-014 SHALL have port dqs_postamble, output, 1 bit: DQS postamble cycle.
REQ-015 SHALL have port dfi_rddata_valid, output, NPHASES bits: read data valid per phase.
REQ-016 SHALL have port phase_err, output, 1 bit: enable seen on an illegal phase.
REQ-017 SHALL have port turn_err, output, 1 bit: read/write window collision.
REQ-018 All outputs SHALL be registered; no combinational input-to-output path.

Function
REQ-019 Write accepted when dfi_wrdata_en[WRPHASE]=1, sampled in cycle t.
- drive_dq and drive_dqs: all bits 1 in cycles t+WRLAT .. t+WRLAT+BURST-1, otherwise 0.
REQ-020 Overlapping or back-to-back writes SHALL produce the union of their windows, with no gap; implementation is a delay line feeding a burst counter reloaded to BURST.
REQ-021 dqs_preamble SHALL be 1 in cycle t+WRLAT-1 only if drive_dqs is 0 in that cycle; it SHALL be suppressed inside a continuous window.
REQ-022 dqs_postamble SHALL be 1 for exactly one cycle: the first cycle with drive_dqs=0 after a cycle with drive_dqs=1.
REQ-023 Read accepted when dfi_rddata_en[RDPHASE]=1 in cycle t.
- dfi_rddata_valid: all bits 1 in cycles t+RDLAT .. t+RDLAT+BURST-1.
- Overlapping reads merge as in REQ-020.
REQ-024 Enable bits on phases other than WRPHASE/RDPHASE SHALL be ignored (no window) and pulse phase_err for 1 cycle, in cycle t+1.
REQ-025 turn_err SHALL pulse 1 cycle (t+1) when either of these holds; the command still executes:
- a read is accepted while any write is pending or driving;
- a write is accepted while any read is pending or valid.
REQ-026 A simultaneous accepted read and write in the same cycle SHALL execute both and pulse turn_err.
REQ-027 Delay lines SHALL be exact: no drop or duplication of enables at maximum command rate (one per cycle).

Reset
REQ-028 While sys_rst_n=0 at a clock edge, all outputs SHALL be 0 and all delay lines and counters SHALL be cleared.
REQ-029 Reset asserted mid-window SHALL cause the following:
- the window terminates at the next edge;
- no postamble is generated;
- commands pending before reset never appear.
REQ-030 The first command sampled after sys_rst_n returns to 1 SHALL obey normal latency.

Configuration
REQ-031 Macro DFI_LATENCY_CTRL_ERR_EN defined: phase_err and turn_err logic built as in REQ-024..026.
REQ-032 Macro DFI_LATENCY_CTRL_ERR_EN undefined: phase_err and turn_err tied 0, with no error logic; all other behaviour identical.

Verification
REQ-033 Write timing:
- stimulus: defaults; dfi_wrdata_en=2'b10 at cycle 10;
- response: preamble at 11, drive_dq=drive_dqs=2'b11 at 12 only, postamble at 13.
REQ-034 Back-to-back writes:
- stimulus: BURST=2, WRLAT=3; writes at cycles 10 and 12;
- response: drive_dq high 13..16 continuous, a single preamble at 12, postamble at 17.
REQ-035 Read timing:
- stimulus: RDLAT=5, BURST=1; dfi_rddata_en=2'b01 at cycles 20 and 21;
- response: dfi_rddata_valid=2'b11 at 25 and 26, 0 at 27.
REQ-036 Illegal phase:
- stimulus: dfi_rddata_en=2'b10 at cycle 30;
- response: phase_err=1 at 31, no valid ever; with macro undefined, phase_err stays 0.
REQ-037 Turnaround:
- stimulus: write at 40, read at 41 (defaults);
- response: turn_err=1 at 42; drive_dq at 42, valid at 46.
REQ-038 Reset mid-window:
- stimulus: BURST=4, write at 50, sys_rst_n=0 at 53;
- response: all outputs 0 from 54, no postamble, nothing further after release.

Source files
------------

// File: rtl/dfi_latency_ctrl.sv
// dfi_latency_ctrl: turns DFI write/read enables into DQ/DQS drive windows,
// DQS preamble/postamble strobes and read-data-valid windows at fixed
// latencies.  Each direction uses a delay line into a burst down-counter
// that reloads on every command, so overlapping windows merge without gaps.
// Build option: define DFI_LATENCY_CTRL_ERR_EN to add the phase_err and
// turn_err detectors; without it both flags are tied low.
module dfi_latency_ctrl #(
    parameter int NPHASES = 2,
    parameter int WRLAT   = 2,
    parameter int RDLAT   = 5,
    parameter int BURST   = 1,
    parameter int WRPHASE = 1,
    parameter int RDPHASE = 0
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic [NPHASES-1:0] dfi_wrdata_en,
    input  logic [NPHASES-1:0] dfi_rddata_en,
    output logic [NPHASES-1:0] drive_dq,
    output logic [NPHASES-1:0] drive_dqs,
    output logic               dqs_preamble,
    output logic               dqs_postamble,
    output logic [NPHASES-1:0] dfi_rddata_valid,
    output logic               phase_err,
    output logic               turn_err
);

    // counter holds the number of window cycles still owed after the current one
    localparam logic [2:0] BURST_LAST = 3'(BURST - 1);

    logic wr_acc;
    logic rd_acc;

    assign wr_acc = dfi_wrdata_en[WRPHASE];
    assign rd_acc = dfi_rddata_en[RDPHASE];

    // ------------------------------------------------------------------
    // write path
    // ------------------------------------------------------------------
    // wr_sr[k] holds a write accepted k+1 cycles ago
    logic [WRLAT-2:0] wr_sr;
    logic             wr_fire;
    logic             wr_prefire;
    logic [2:0]       wr_cnt;
    logic             wr_on;
    logic             wr_on_nxt;

    // write delay line: one stage per cycle of latency, cleared on reset
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            wr_sr <= '0;
        end else begin
            wr_sr[0] <= wr_acc;
            for (int i = 1; i < WRLAT - 1; i++) begin
                wr_sr[i] <= wr_sr[i-1];
            end
        end
    end

    // fire is the cycle before the first drive cycle; prefire one cycle earlier
    assign wr_fire = wr_sr[WRLAT-2];

    generate
        if (WRLAT == 2) begin : g_wr_pre_direct
            assign wr_prefire = wr_acc;
        end else begin : g_wr_pre_tap
            assign wr_prefire = wr_sr[WRLAT-3];
        end
    endgenerate

    assign wr_on_nxt = wr_fire || (wr_cnt != 3'd0);

    // write burst down-counter, reloaded by each arriving command
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            wr_cnt <= 3'd0;
            wr_on  <= 1'b0;
        end else begin
            if (wr_fire) begin
                wr_cnt <= BURST_LAST;
            end else if (wr_cnt != 3'd0) begin
                wr_cnt <= wr_cnt - 3'd1;
            end
            wr_on <= wr_on_nxt;
        end
    end

    // DQS framing: preamble only ahead of a fresh window, postamble on the falling edge of one
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            dqs_preamble  <= 1'b0;
            dqs_postamble <= 1'b0;
        end else begin
            dqs_preamble  <= wr_prefire && !wr_on_nxt;
            dqs_postamble <= wr_on && !wr_on_nxt;
        end
    end

    assign drive_dq  = {NPHASES{wr_on}};
    assign drive_dqs = {NPHASES{wr_on}};

    // ------------------------------------------------------------------
    // read path
    // ------------------------------------------------------------------
    logic       rd_fire;
    logic [2:0] rd_cnt;
    logic       rd_on;

`ifdef DFI_LATENCY_CTRL_ERR_EN
    logic rd_pend;
`endif

    generate
        if (RDLAT == 1) begin : g_rd_direct
            assign rd_fire = rd_acc;
`ifdef DFI_LATENCY_CTRL_ERR_EN
            assign rd_pend = 1'b0;
`endif
        end else begin : g_rd_dly
            logic [RDLAT-2:0] rd_sr;

            // read delay line, same structure as the write side
            always_ff @(posedge sys_clk) begin
                if (!sys_rst_n) begin
                    rd_sr <= '0;
                end else begin
                    rd_sr[0] <= rd_acc;
                    for (int i = 1; i < RDLAT - 1; i++) begin
                        rd_sr[i] <= rd_sr[i-1];
                    end
                end
            end

            assign rd_fire = rd_sr[RDLAT-2];
`ifdef DFI_LATENCY_CTRL_ERR_EN
            assign rd_pend = |rd_sr;
`endif
        end
    endgenerate

    // read burst down-counter, reloaded by each arriving command
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            rd_cnt <= 3'd0;
            rd_on  <= 1'b0;
        end else begin
            if (rd_fire) begin
                rd_cnt <= BURST_LAST;
            end else if (rd_cnt != 3'd0) begin
                rd_cnt <= rd_cnt - 3'd1;
            end
            rd_on <= rd_fire || (rd_cnt != 3'd0);
        end
    end

    assign dfi_rddata_valid = {NPHASES{rd_on}};

    // ------------------------------------------------------------------
    // error detection
    // ------------------------------------------------------------------
`ifdef DFI_LATENCY_CTRL_ERR_EN
    logic [NPHASES-1:0] wr_other;
    logic [NPHASES-1:0] rd_other;
    logic               wr_busy;
    logic               rd_busy;

    // a direction is busy from acceptance until the last window cycle
    assign wr_busy = (|wr_sr) || wr_on;
    assign rd_busy = rd_pend || rd_on;

    // strip the accepted phase so only stray enables remain
    always_comb begin
        wr_other          = dfi_wrdata_en;
        rd_other          = dfi_rddata_en;
        wr_other[WRPHASE] = 1'b0;
        rd_other[RDPHASE] = 1'b0;
    end

    // one-cycle error pulses registered the cycle after the offending command
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            phase_err <= 1'b0;
            turn_err  <= 1'b0;
        end else begin
            phase_err <= (|wr_other) || (|rd_other);
            turn_err  <= (rd_acc && (wr_acc || wr_busy)) || (wr_acc && rd_busy);
        end
    end
`else
    assign phase_err = 1'b0;
    assign turn_err  = 1'b0;
`endif

endmodule

// File: tb/tb_dfi_latency_ctrl.sv
// tb_dfi_latency_ctrl: four parameterisations driven from one stimulus
// stream (directed opening, then random with occasional resets) and checked
// every cycle against a window-based reference model built from the command
// history.
module tb_dfi_latency_ctrl;

    localparam int NCYC = 2500;
`ifdef DFI_LATENCY_CTRL_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic       sys_clk;
    logic       sys_rst_n;
    logic [1:0] w2, r2;
    logic [3:0] w4, r4;

    logic [1:0] dq_a, dqs_a, val_a;
    logic       pre_a, post_a, perr_a, terr_a;
    logic [1:0] dq_b, dqs_b, val_b;
    logic       pre_b, post_b, perr_b, terr_b;
    logic [1:0] dq_c, dqs_c, val_c;
    logic       pre_c, post_c, perr_c, terr_c;
    logic [3:0] dq_d, dqs_d, val_d;
    logic       pre_d, post_d, perr_d, terr_d;

    dfi_latency_ctrl u_dut_a (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .dfi_wrdata_en(w2), .dfi_rddata_en(r2),
        .drive_dq(dq_a), .drive_dqs(dqs_a),
        .dqs_preamble(pre_a), .dqs_postamble(post_a),
        .dfi_rddata_valid(val_a), .phase_err(perr_a), .turn_err(terr_a)
    );

    dfi_latency_ctrl #(.WRLAT(3), .RDLAT(16), .BURST(2)) u_dut_b (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .dfi_wrdata_en(w2), .dfi_rddata_en(r2),
        .drive_dq(dq_b), .drive_dqs(dqs_b),
        .dqs_preamble(pre_b), .dqs_postamble(post_b),
        .dfi_rddata_valid(val_b), .phase_err(perr_b), .turn_err(terr_b)
    );

    dfi_latency_ctrl #(.BURST(4)) u_dut_c (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .dfi_wrdata_en(w2), .dfi_rddata_en(r2),
        .drive_dq(dq_c), .drive_dqs(dqs_c),
        .dqs_preamble(pre_c), .dqs_postamble(post_c),
        .dfi_rddata_valid(val_c), .phase_err(perr_c), .turn_err(terr_c)
    );

    dfi_latency_ctrl #(.NPHASES(4), .WRLAT(8), .RDLAT(1), .BURST(3),
                       .WRPHASE(3), .RDPHASE(2)) u_dut_d (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .dfi_wrdata_en(w4), .dfi_rddata_en(r4),
        .drive_dq(dq_d), .drive_dqs(dqs_d),
        .dqs_preamble(pre_d), .dqs_postamble(post_d),
        .dfi_rddata_valid(val_d), .phase_err(perr_d), .turn_err(terr_d)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // command history, one entry per cycle
    bit       h_rstn [NCYC];
    bit [1:0] h_w2   [NCYC];
    bit [1:0] h_r2   [NCYC];
    bit [3:0] h_w4   [NCYC];
    bit [3:0] h_r4   [NCYC];

    function automatic int nph(int i);   return (i == 3) ? 4 : 2; endfunction
    function automatic int wrph(int i);  return (i == 3) ? 3 : 1; endfunction
    function automatic int rdph(int i);  return (i == 3) ? 2 : 0; endfunction
    function automatic int wrlat(int i);
        case (i) 1: return 3; 3: return 8; default: return 2; endcase
    endfunction
    function automatic int rdlat(int i);
        case (i) 1: return 16; 3: return 1; default: return 5; endcase
    endfunction
    function automatic int burst(int i);
        case (i) 1: return 2; 2: return 4; 3: return 3; default: return 1; endcase
    endfunction

    // true when reset was high in every cycle a..b
    function automatic bit rst_ok(int a, int b);
        if (a < 0) return 1'b0;
        for (int k = a; k <= b; k++) if (!h_rstn[k]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit cmd(int i, bit rd, int t);
        bit [3:0] v;
        if (t < 0) return 1'b0;
        if (i == 3) v = rd ? h_r4[t] : h_w4[t];
        else        v = rd ? {2'b00, h_r2[t]} : {2'b00, h_w2[t]};
        return v[rd ? rdph(i) : wrph(i)];
    endfunction

    // output window active in cycle c: some surviving command lands on it
    function automatic bit win(int i, bit rd, int c);
        int lat = rd ? rdlat(i) : wrlat(i);
        for (int t = c - lat - burst(i) + 1; t <= c - lat; t++)
            if (cmd(i, rd, t) && rst_ok(t, c - 1)) return 1'b1;
        return 1'b0;
    endfunction

    // a surviving earlier command whose window has not finished by cycle t
    function automatic bit busy(int i, bit rd, int t);
        int lat = rd ? rdlat(i) : wrlat(i);
        for (int tp = t - lat - burst(i) + 1; tp <= t - 1; tp++)
            if (cmd(i, rd, tp) && rst_ok(tp, t - 1)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit pre_exp(int i, int c);
        int t = c - wrlat(i) + 1;
        return cmd(i, 1'b0, t) && rst_ok(t, c - 1) && !win(i, 1'b0, c);
    endfunction

    function automatic bit post_exp(int i, int c);
        return win(i, 1'b0, c - 1) && !win(i, 1'b0, c) && rst_ok(c - 1, c - 1);
    endfunction

    function automatic bit perr_exp(int i, int c);
        bit [3:0] w, r;
        int t = c - 1;
        if (!ERR_EN || !rst_ok(t, t)) return 1'b0;
        w = (i == 3) ? h_w4[t] : {2'b00, h_w2[t]};
        r = (i == 3) ? h_r4[t] : {2'b00, h_r2[t]};
        w[wrph(i)] = 1'b0;
        r[rdph(i)] = 1'b0;
        return (w | r) != 4'd0;
    endfunction

    function automatic bit terr_exp(int i, int c);
        int t = c - 1;
        bit wr, rd;
        if (!ERR_EN || !rst_ok(t, t)) return 1'b0;
        wr = cmd(i, 1'b0, t);
        rd = cmd(i, 1'b1, t);
        return (rd && (wr || busy(i, 1'b0, t))) || (wr && busy(i, 1'b1, t));
    endfunction

    function automatic logic [3:0] vec(int i, bit on);
        return on ? ((4'd1 << nph(i)) - 4'd1) : 4'd0;
    endfunction

    task automatic check_inst(input int i, input int c,
                              input logic [3:0] dq, input logic [3:0] dqs, input logic [3:0] val,
                              input logic pre, input logic post, input logic perr, input logic terr);
        bit wo = win(i, 1'b0, c);
        check($sformatf("i%0d_dq@%0d", i, c),   dq,   vec(i, wo));
        check($sformatf("i%0d_dqs@%0d", i, c),  dqs,  vec(i, wo));
        check($sformatf("i%0d_val@%0d", i, c),  val,  vec(i, win(i, 1'b1, c)));
        check($sformatf("i%0d_pre@%0d", i, c),  pre,  pre_exp(i, c));
        check($sformatf("i%0d_post@%0d", i, c), post, post_exp(i, c));
        check($sformatf("i%0d_perr@%0d", i, c), perr, perr_exp(i, c));
        check($sformatf("i%0d_terr@%0d", i, c), terr, terr_exp(i, c));
    endtask

    task automatic gen_inputs(input int c);
        sys_rst_n = (c >= 2);
        w2 = 2'b00; r2 = 2'b00; w4 = 4'h0; r4 = 4'h0;
        if (c < 60) begin
            case (c)
                10, 12, 40, 50: w2 = 2'b10;
                20, 21, 41:     r2 = 2'b01;
                30:             r2 = 2'b10;
                53:             sys_rst_n = 1'b0;
                default: ;
            endcase
        end else begin
            sys_rst_n = ($urandom_range(0, 79) != 0);
            for (int b = 0; b < 2; b++) begin
                w2[b] = ($urandom_range(0, 9) < 3);
                r2[b] = ($urandom_range(0, 9) < 3);
            end
            for (int b = 0; b < 4; b++) begin
                w4[b] = ($urandom_range(0, 9) < 2);
                r4[b] = ($urandom_range(0, 9) < 2);
            end
        end
    endtask

    // fixed spot checks taken straight from the expected waveforms
    task automatic directed_checks(input int c);
        case (c)
            11: check("a_wr_pre", pre_a, 1'b1);
            12: begin
                check("a_wr_dq", dq_a, 2'b11);
                check("a_wr_dqs", dqs_a, 2'b11);
                check("b_b2b_pre", pre_b, 1'b1);
            end
            13: begin
                check("a_wr_dq_end", dq_a, 2'b00);
                check("a_wr_post", post_a, 1'b1);
                check("b_b2b_dq13", dq_b, 2'b11);
            end
            14: begin
                check("b_b2b_dq14", dq_b, 2'b11);
                check("b_b2b_pre_supp", pre_b, 1'b0);
            end
            15: check("b_b2b_dq15", dq_b, 2'b11);
            16: begin
                check("b_b2b_dq16", dq_b, 2'b11);
                check("b_b2b_nopost16", post_b, 1'b0);
            end
            17: begin
                check("b_b2b_dq17", dq_b, 2'b00);
                check("b_b2b_post", post_b, 1'b1);
            end
            25: check("a_rd_val25", val_a, 2'b11);
            26: check("a_rd_val26", val_a, 2'b11);
            27: check("a_rd_val27", val_a, 2'b00);
            31: check("a_phase_err", perr_a, ERR_EN);
            35: check("a_illegal_noval", val_a, 2'b00);
            42: begin
                check("a_turn_err", terr_a, ERR_EN);
                check("a_turn_dq", dq_a, 2'b11);
            end
            46: check("a_turn_val", val_a, 2'b11);
            53: check("c_rst_dq53", dq_c, 2'b11);
            54: begin
                check("c_rst_dq54", dq_c, 2'b00);
                check("c_rst_nopost", post_c, 1'b0);
            end
            56: check("c_rst_after", dqs_c, 2'b00);
            default: ;
        endcase
    endtask

    initial begin
        sys_rst_n = 1'b0;
        w2 = 2'b00; r2 = 2'b00; w4 = 4'h0; r4 = 4'h0;
        for (int c = 0; c < NCYC; c++) begin
            @(posedge sys_clk);
            #1;
            gen_inputs(c);
            h_rstn[c] = sys_rst_n;
            h_w2[c]   = w2;
            h_r2[c]   = r2;
            h_w4[c]   = w4;
            h_r4[c]   = r4;
            @(negedge sys_clk);
            check_inst(0, c, {2'b00, dq_a}, {2'b00, dqs_a}, {2'b00, val_a}, pre_a, post_a, perr_a, terr_a);
            check_inst(1, c, {2'b00, dq_b}, {2'b00, dqs_b}, {2'b00, val_b}, pre_b, post_b, perr_b, terr_b);
            check_inst(2, c, {2'b00, dq_c}, {2'b00, dqs_c}, {2'b00, val_c}, pre_c, post_c, perr_c, terr_c);
            check_inst(3, c, dq_d, dqs_d, val_d, pre_d, post_d, perr_d, terr_d);
            directed_checks(c);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
